// File: rtl/pretrigger_mc_if.sv
// Bus bundle for pretrigger_mc: channel hits, trigger configuration, test-pulse controls and trigger outputs.
interface pretrigger_mc_if #(
    parameter int N_CH       = 8,
    parameter int SIZE_DELAY = 4,
    parameter int SIZE_GATE  = 4,
    parameter int SIZE_DEAD  = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int TH_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]       ch_in;
    logic [N_CH-1:0]       ch_mask;
    logic [TH_W-1:0]       threshold;
    logic [SIZE_GATE-1:0]  gate_len;
    logic [SIZE_DEAD-1:0]  dead_time;
    logic                  test_overlay;
    logic                  test_rate;
    logic [SIZE_DELAY-1:0] test_delay;
    logic                  trig_out;
    logic                  busy;
    logic                  test_pulse;
    logic [CNT_WIDTH-1:0]  trig_cnt;

    modport master (
        output ch_in, ch_mask, threshold, gate_len, dead_time,
               test_overlay, test_rate, test_delay,
        input  trig_out, busy, test_pulse, trig_cnt
    );

    modport slave (
        input  ch_in, ch_mask, threshold, gate_len, dead_time,
               test_overlay, test_rate, test_delay,
        output trig_out, busy, test_pulse, trig_cnt
    );
endinterface

// File: rtl/pretrigger_mc.sv
// Multi-channel majority pre-trigger: edge-detected hits open per-channel coincidence gates, a registered
// majority count fires a TRIG_LEN trigger followed by dead time. Test generator built under PRETRIG_TEST_GEN_EN.
module pretrigger_mc #(
    parameter int N_CH        = 8,
    parameter int SIZE_DELAY  = 4,
    parameter int SIZE_GATE   = 4,
    parameter int SIZE_DEAD   = 8,
    parameter int TRIG_LEN    = 4,
    parameter int TEST_PERIOD = 1000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           reset,
    pretrigger_mc_if.slave bus
);
    localparam int CW = $clog2(N_CH + 1);
    localparam int TW = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;

    typedef enum logic [1:0] {IDLE, FIRE, DEAD} state_t;

    state_t               state, state_n;
    logic                 fire;
    logic [N_CH-1:0]      ch_q, ch_qq, hit, hit_eff, open_g;
    logic [SIZE_GATE-1:0] gate [N_CH];
    logic [CW-1:0]        pop, count;
    logic                 cond;
    logic                 inject;
    logic [TW-1:0]        tcnt;
    logic [SIZE_DEAD-1:0] dead_q, dcnt;
    logic [CNT_WIDTH-1:0] trig_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q  <= '0;
            ch_qq <= '0;
        end else begin
            ch_q  <= bus.ch_in;
            ch_qq <= ch_q;
        end
    end

    assign hit = ch_q & ~ch_qq;

`ifdef PRETRIG_TEST_GEN_EN
    localparam int PW = $clog2(TEST_PERIOD);

    logic [PW-1:0]         per_cnt;
    logic [SIZE_DELAY-1:0] dly_cnt;
    logic                  pending, tick, pulse_now, test_pulse_q;

    assign tick      = bus.test_rate && (per_cnt == PW'(TEST_PERIOD - 1));
    assign pulse_now = bus.test_rate && pending && (dly_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || !bus.test_rate) begin
            per_cnt      <= '0;
            dly_cnt      <= '0;
            pending      <= 1'b0;
            test_pulse_q <= 1'b0;
        end else begin
            per_cnt      <= tick ? '0 : per_cnt + 1'b1;
            test_pulse_q <= pulse_now;
            if (pending) begin
                if (dly_cnt == '0) pending <= 1'b0;
                else               dly_cnt <= dly_cnt - 1'b1;
            end else if (tick) begin
                pending <= 1'b1;
                dly_cnt <= bus.test_delay;
            end
        end
    end

    // Gates load on the same edge that raises test_pulse, so injected pulses bypass the input registers.
    assign inject         = pulse_now & bus.test_overlay;
    assign bus.test_pulse = test_pulse_q;
`else
    logic unused_test;
    localparam int unused_cfg = TEST_PERIOD + SIZE_DELAY;

    assign unused_test    = bus.test_overlay ^ bus.test_rate ^ (^bus.test_delay);
    assign inject         = 1'b0;
    assign bus.test_pulse = 1'b0;
`endif

    assign hit_eff = hit | {N_CH{inject}};

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (reset || fire)         gate[i] <= '0;
            else if (hit_eff[i])       gate[i] <= bus.gate_len;
            else if (gate[i] != '0)    gate[i] <= gate[i] - 1'b1;
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            open_g[i] = (gate[i] != '0);
            pop = pop + CW'(open_g[i] & ~bus.ch_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= pop;
    end

    assign cond = (bus.threshold != '0) && (count >= bus.threshold);

    // A coincidence present as dead time expires re-fires directly, giving a TRIG_LEN+dead_time minimum period.
    always_comb begin
        state_n = state;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                if (cond) begin
                    state_n = FIRE;
                    fire    = 1'b1;
                end
            end
            FIRE: begin
                if (tcnt == '0) state_n = (dead_q != '0) ? DEAD : IDLE;
            end
            DEAD: begin
                if (dcnt == '0) begin
                    if (cond) begin
                        state_n = FIRE;
                        fire    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tcnt       <= '0;
            dead_q     <= '0;
            dcnt       <= '0;
            trig_cnt_q <= '0;
        end else begin
            state <= state_n;
            if (fire) begin
                tcnt   <= TW'(TRIG_LEN - 1);
                dead_q <= bus.dead_time;
                if (trig_cnt_q != '1) trig_cnt_q <= trig_cnt_q + 1'b1;
            end else if (state == FIRE && tcnt != '0) begin
                tcnt <= tcnt - 1'b1;
            end
            if (state == FIRE && state_n == DEAD)   dcnt <= dead_q - 1'b1;
            else if (state == DEAD && dcnt != '0)   dcnt <= dcnt - 1'b1;
        end
    end

    assign bus.trig_out = (state == FIRE);
    assign bus.busy     = (state != IDLE);
    assign bus.trig_cnt = trig_cnt_q;
endmodule

// File: tb/tb_pretrigger_mc.sv
// Directed bench for pretrigger_mc; a second instance with CNT_WIDTH=2 mirrors the stimulus for saturation.
module tb_pretrigger_mc;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] pat [16];

`ifdef PRETRIG_TEST_GEN_EN
    localparam bit TG = 1'b1;
`else
    localparam bit TG = 1'b0;
`endif

    always #5 clk = ~clk;

    pretrigger_mc_if #(.N_CH(8), .SIZE_DELAY(4), .SIZE_GATE(4), .SIZE_DEAD(8), .CNT_WIDTH(16)) bus ();
    pretrigger_mc_if #(.N_CH(8), .SIZE_DELAY(4), .SIZE_GATE(4), .SIZE_DEAD(8), .CNT_WIDTH(2))  bus2 ();

    pretrigger_mc #(
        .N_CH(8), .SIZE_DELAY(4), .SIZE_GATE(4), .SIZE_DEAD(8),
        .TRIG_LEN(4), .TEST_PERIOD(20), .CNT_WIDTH(16)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    pretrigger_mc #(
        .N_CH(8), .SIZE_DELAY(4), .SIZE_GATE(4), .SIZE_DEAD(8),
        .TRIG_LEN(4), .TEST_PERIOD(20), .CNT_WIDTH(2)
    ) dut_sat (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.ch_in        = bus.ch_in;
    assign bus2.ch_mask      = bus.ch_mask;
    assign bus2.threshold    = bus.threshold;
    assign bus2.gate_len     = bus.gate_len;
    assign bus2.dead_time    = bus.dead_time;
    assign bus2.test_overlay = bus.test_overlay;
    assign bus2.test_rate    = bus.test_rate;
    assign bus2.test_delay   = bus.test_delay;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.ch_in = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 16; i++) pat[i] = '0;
    endtask

    // pat[k] is sampled at edge k; bit k of the masks is the expected output after edge k
    task automatic run_pattern(input string tag, input logic [15:0] exp_trig, input logic [15:0] exp_busy);
        for (int k = 0; k < 16; k++) begin
            bus.ch_in = pat[k];
            step();
            check({tag, ".trig"}, 32'(bus.trig_out), 32'(exp_trig[k]));
            check({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy[k]));
        end
        idle(4);
    endtask

    initial begin
        bus.ch_in        = '0;
        bus.ch_mask      = '0;
        bus.threshold    = 4'd3;
        bus.gate_len     = 4'd4;
        bus.dead_time    = 8'd0;
        bus.test_overlay = 1'b0;
        bus.test_rate    = 1'b0;
        bus.test_delay   = 4'd3;
        reset = 1'b1;
        step();
        step();
        check("rst.trig", 32'(bus.trig_out), 0);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.tp",   32'(bus.test_pulse), 0);
        check("rst.cnt",  32'(bus.trig_cnt), 0);
        reset = 1'b0;
        idle(3);

        clear_pat(); pat[0] = 8'h01; pat[2] = 8'h02; pat[3] = 8'h04;
        run_pattern("coinc", 16'h03C0, 16'h03C0);
        check("coinc.cnt", 32'(bus.trig_cnt), 1);

        clear_pat(); pat[0] = 8'h01; pat[2] = 8'h02; pat[5] = 8'h04;
        run_pattern("late", 16'h0000, 16'h0000);

        clear_pat(); pat[0] = 8'h03; pat[4] = 8'h04;
        run_pattern("sep_eq_gate", 16'h0000, 16'h0000);

        bus.ch_mask = 8'h04;
        clear_pat(); pat[0] = 8'h07;
        run_pattern("masked", 16'h0000, 16'h0000);
        bus.ch_mask = '0;
        check("masked.cnt", 32'(bus.trig_cnt), 1);

        bus.threshold = 4'd0;
        clear_pat(); pat[0] = 8'hFF;
        run_pattern("thr0", 16'h0000, 16'h0000);
        bus.threshold = 4'd9;
        run_pattern("thr9", 16'h0000, 16'h0000);
        bus.threshold = 4'd3;
        bus.gate_len  = 4'd0;
        run_pattern("gate0", 16'h0000, 16'h0000);
        bus.gate_len  = 4'd4;
        bus.threshold = 4'd8;
        run_pattern("thr8", 16'h0078, 16'h0078);
        check("thr8.cnt", 32'(bus.trig_cnt), 2);

        bus.threshold = 4'd3;
        for (int i = 0; i < 16; i++) pat[i] = 8'h07;
        run_pattern("held", 16'h0078, 16'h0078);
        check("held.cnt", 32'(bus.trig_cnt), 3);

        // dead time 10: first fire at edge 3, re-fires at 17, 31, 45; busy until edge 58
        bus.dead_time = 8'd10;
        bus.gate_len  = 4'd8;
        for (int k = 0; k < 65; k++) begin
            bus.ch_in = (k % 5 == 0 && k < 50) ? 8'h07 : 8'h00;
            step();
            check("dead.trig", 32'(bus.trig_out),
                  32'((k >= 3 && k < 7) || (k >= 17 && k < 21) || (k >= 31 && k < 35) || (k >= 45 && k < 49)));
            check("dead.busy", 32'(bus.busy), 32'(k >= 3 && k <= 58));
        end
        idle(4);
        check("dead.cnt", 32'(bus.trig_cnt), 7);
        bus.dead_time = 8'd0;
        bus.gate_len  = 4'd4;

        // test generator: tick at edge 19, 39, 59, 79; pulse 4 later; trigger 2 after pulse
        bus.threshold  = 4'd8;
        bus.test_delay = 4'd3;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.test_rate = 1'b1;
        for (int k = 0; k < 90; k++) begin
            bus.test_overlay = (k < 70);
            step();
            check("tg.pulse", 32'(bus.test_pulse), 32'(TG && (k == 23 || k == 43 || k == 63 || k == 83)));
            check("tg.trig", 32'(bus.trig_out),
                  32'(TG && ((k >= 25 && k < 29) || (k >= 45 && k < 49) || (k >= 65 && k < 69))));
        end
        bus.test_rate    = 1'b0;
        bus.test_overlay = 1'b0;
        idle(4);
        check("tg.cnt", 32'(bus.trig_cnt), TG ? 3 : 0);

        // reset while firing
        bus.threshold = 4'd3;
        bus.dead_time = 8'd10;
        bus.ch_in = 8'h07;
        step();
        idle(3);
        check("rstfire.trig_pre", 32'(bus.trig_out), 1);
        reset = 1'b1;
        step();
        check("rstfire.trig", 32'(bus.trig_out), 0);
        check("rstfire.busy", 32'(bus.busy), 0);
        check("rstfire.cnt",  32'(bus.trig_cnt), 0);
        check("rstfire.cnt2", 32'(bus2.trig_cnt), 0);
        reset = 1'b0;
        bus.dead_time = 8'd0;
        idle(4);

        bus.threshold = 4'd8;
        for (int n = 0; n < 5; n++) begin
            bus.ch_in = 8'hFF;
            step();
            idle(8);
        end
        check("sat.cnt16", 32'(bus.trig_cnt), 5);
        check("sat.cnt2",  32'(bus2.trig_cnt), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
